// File: rtl/alu_pkg.sv
// Definitions shared by the ALU units: opcode encodings and the
// sequential-unit state type.
package alu_pkg;

    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA) ||
               (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shift/rotate of x by k (k <= STEP) positions, built from
// k single-bit moves so carry_out is naturally the last bit moved or wrapped.
module shift_step
    import alu_pkg::*;
#(
    parameter  int WIDTH = 6,
    parameter  int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [AMT_W-1:0] k,
    output logic [WIDTH-1:0] x_next,
    output logic             carry_out
);

    always_comb begin
        x_next    = x;
        carry_out = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (AMT_W'(i) < k) begin
                case (op)
                    OP_SRL: begin
                        carry_out = x_next[0];
                        x_next    = {1'b0, x_next[WIDTH-1:1]};
                    end
                    OP_SLL: begin
                        carry_out = x_next[WIDTH-1];
                        x_next    = {x_next[WIDTH-2:0], 1'b0};
                    end
                    OP_SRA: begin
                        carry_out = x_next[0];
                        x_next    = {x_next[WIDTH-1], x_next[WIDTH-1:1]};
                    end
                    OP_ROR: begin
                        carry_out = x_next[0];
                        x_next    = {x_next[0], x_next[WIDTH-1:1]};
                    end
                    OP_ROL: begin
                        carry_out = x_next[WIDTH-1];
                        x_next    = {x_next[WIDTH-2:0], x_next[WIDTH-1]};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/alu_seq_shifter.sv
// Multi-cycle shifter/rotator: moves operand A by up to STEP bits per clock,
// with valid/ready handshakes on both the operand and result sides.
module alu_seq_shifter
    import alu_pkg::*;
#(
    parameter  int WIDTH = 6,
    parameter  int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       instruction,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] X,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

    state_t           state, state_next;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] k;
    logic [AMT_W-1:0] amt;
    logic [3:0]       op;
    logic [WIDTH-1:0] step_x;
    logic             step_carry;

    assign amt       = B[AMT_W-1:0];
    assign k         = (rem < STEP_A) ? rem : STEP_A;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign zero      = (X == '0);

    if (WIDTH > AMT_W) begin : g_unused_b
        logic unused_b;
        assign unused_b = ^B[WIDTH-1:AMT_W];
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_shift_step (
        .op        (op),
        .x         (X),
        .k         (k),
        .x_next    (step_x),
        .carry_out (step_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Zero amounts and illegal opcodes skip SHIFT and report straight away.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (amt == '0 || !is_shift_op(instruction)) state_next = DONE;
                    else                                        state_next = SHIFT;
                end
            end
            SHIFT:   if (rem <= STEP_A) state_next = DONE;
            DONE:    if (out_ready)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            X     <= '0;
            rem   <= '0;
            op    <= '0;
            carry <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        X     <= A;
                        rem   <= amt;
                        op    <= instruction;
                        carry <= 1'b0;
                        err   <= !is_shift_op(instruction);
                    end
                end
                SHIFT: begin
                    X     <= step_x;
                    carry <= step_carry;
                    rem   <= rem - k;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_shifter.sv
// Directed bench for alu_seq_shifter: one instance with STEP=1 and one with
// STEP=2, each operation checked for result, flags and handshake latency.
module tb_alu_seq_shifter;
    import alu_pkg::*;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         iv   [2];
    logic         ordy [2];
    logic [3:0]   ins  [2];
    logic [W-1:0] a    [2];
    logic [W-1:0] b    [2];
    logic         ir   [2];
    logic         ov   [2];
    logic         cy   [2];
    logic         zr   [2];
    logic         er   [2];
    logic [W-1:0] x    [2];

    int errors = 0;
    int checks = 0;
    int n;

    alu_seq_shifter #(.WIDTH(W), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .instruction(ins[0]), .A(a[0]), .B(b[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .X(x[0]), .carry(cy[0]), .zero(zr[0]), .err(er[0])
    );

    alu_seq_shifter #(.WIDTH(W), .STEP(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .instruction(ins[1]), .A(a[1]), .B(b[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .X(x[1]), .carry(cy[1]), .zero(zr[1]), .err(er[1])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one operation, then counts rising edges after accept until out_valid.
    task automatic applyStimulus(input int i, input logic [3:0] opc,
                                 input logic [W-1:0] av, input logic [W-1:0] bv,
                                 output int edges);
        @(negedge clk);
        iv[i] = 1'b1; ins[i] = opc; a[i] = av; b[i] = bv;
        @(posedge clk);
        @(negedge clk);
        iv[i] = 1'b0; a[i] = ~av; b[i] = ~bv;
        edges = 0;
        while (!ov[i] && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        if (!ov[i]) checkOutput("out_valid_timeout", {31'd0, ov[i]}, 32'd1);
    endtask

    task automatic checkResult(input int i, input string tag, input logic [W-1:0] ex,
                               input logic ec, input logic ez, input logic ee,
                               input int en, input int edges);
        checkOutput({tag, "_x"}, 32'(x[i]), 32'(ex));
        checkOutput({tag, "_carry"}, {31'd0, cy[i]}, {31'd0, ec});
        checkOutput({tag, "_zero"}, {31'd0, zr[i]}, {31'd0, ez});
        checkOutput({tag, "_err"}, {31'd0, er[i]}, {31'd0, ee});
        checkOutput({tag, "_edges"}, edges, en);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1; ins[i] = '0; a[i] = '0; b[i] = '0;
        end
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, ir[0]}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, ov[0]}, 32'd0);
        checkOutput("rst_x", 32'(x[0]), 32'd0);
        checkOutput("rst_carry", {31'd0, cy[0]}, 32'd0);
        checkOutput("rst_zero", {31'd0, zr[0]}, 32'd1);
        checkOutput("rst_err", {31'd0, er[0]}, 32'd0);
        rst_n = 1'b1;

        applyStimulus(0, OP_SRL, 6'b111000, 6'b000011, n);
        checkResult(0, "srl_s1", 6'b000111, 1'b0, 1'b0, 1'b0, 3, n);

        applyStimulus(0, OP_ROR, 6'b111000, 6'b000111, n);
        checkResult(0, "ror7_s1", 6'b011100, 1'b0, 1'b0, 1'b0, 7, n);

        applyStimulus(0, OP_SLL, 6'b101010, 6'b111011, n);
        checkResult(0, "sll_s1", 6'b010000, 1'b1, 1'b0, 1'b0, 3, n);

        applyStimulus(0, OP_SLL, 6'b010101, 6'b111000, n);
        checkResult(0, "amt0_s1", 6'b010101, 1'b0, 1'b0, 1'b0, 0, n);

        applyStimulus(1, OP_SRA, 6'b101010, 6'b101010, n);
        checkResult(1, "sra_s2", 6'b111010, 1'b1, 1'b0, 1'b0, 1, n);

        applyStimulus(1, OP_SRL, 6'b111111, 6'b000110, n);
        checkResult(1, "srl6_s2", 6'b000000, 1'b1, 1'b1, 1'b0, 3, n);

        applyStimulus(1, OP_SRA, 6'b100000, 6'b000111, n);
        checkResult(1, "sra7_s2", 6'b111111, 1'b1, 1'b0, 1'b0, 4, n);

        applyStimulus(1, OP_ROL, 6'b101001, 6'b000011, n);
        checkResult(1, "rol3_s2", 6'b001101, 1'b1, 1'b0, 1'b0, 2, n);

        // Illegal opcode with the consumer stalled; new operands must be ignored.
        ordy[0] = 1'b0;
        applyStimulus(0, 4'b1111, 6'b001100, 6'b000011, n);
        checkResult(0, "illegal", 6'b001100, 1'b0, 1'b0, 1'b1, 0, n);
        for (int c = 0; c < 5; c++) begin
            iv[0] = 1'b1; ins[0] = OP_SLL; a[0] = 6'b111111; b[0] = 6'b000001;
            @(negedge clk);
            checkOutput("stall_out_valid", {31'd0, ov[0]}, 32'd1);
            checkOutput("stall_in_ready", {31'd0, ir[0]}, 32'd0);
            checkOutput("stall_x", 32'(x[0]), 32'(6'b001100));
            checkOutput("stall_err", {31'd0, er[0]}, 32'd1);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", {31'd0, ir[0]}, 32'd1);
        checkOutput("release_out_valid", {31'd0, ov[0]}, 32'd0);

        // Reset pulsed after two shift cycles of a five-bit SLL.
        iv[0] = 1'b1; ins[0] = OP_SLL; a[0] = 6'b111111; b[0] = 6'd5;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("midshift_busy", {31'd0, ir[0]}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_x", 32'(x[0]), 32'd0);
        checkOutput("midrst_zero", {31'd0, zr[0]}, 32'd1);
        checkOutput("midrst_out_valid", {31'd0, ov[0]}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, ir[0]}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("postrst_no_valid", {31'd0, ov[0]}, 32'd0);

        applyStimulus(0, OP_SRL, 6'b100000, 6'b000001, n);
        checkResult(0, "postrst_srl", 6'b010000, 1'b0, 1'b0, 1'b0, 1, n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_shifter.md
# alu_seq_shifter

Parametrised, multi-cycle successor to the fixed 3-bit right shifter in the ALU. It shifts or rotates a WIDTH-bit operand A by a variable amount taken from operand B, moving at most STEP bit positions per clock. Operands enter through a valid/ready handshake, and the result leaves through another valid/ready handshake. It sits beside the combinational ALU units and shares their 4-bit instruction encoding.

## Interface
- WIDTH, 6: operand and result width, ≥2.
- STEP, 1: maximum bit positions moved per clock, 1 ≤ STEP ≤ WIDTH.
- AMT_W, $clog2(WIDTH+1): derived; low B bits used as shift amount.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction, A and B are valid.
- in_ready  out  1  block can accept; high only in IDLE.
- instruction  in  4  opcode; sampled at accept.
- A  in  WIDTH  operand to shift.
- B  in  WIDTH  amount = B[AMT_W-1:0], unsigned; upper bits ignored.
- out_valid  out  1  X, carry, zero, err valid; high only in DONE.
- out_ready  in  1  consumer takes the result.
- X  out  WIDTH  result register.
- carry  out  1  last bit shifted out, or last bit wrapped for rotates; 0 if amount = 0.
- zero  out  1  X == 0.
- err  out  1  illegal opcode.

## Operation
- Opcodes:
  - 0110 SRL: shift right, zero fill.
  - 0111 SLL: shift left, zero fill.
  - 1000 SRA: shift right, sign fill from A[WIDTH-1].
  - 1001 ROR: rotate right.
  - 1010 ROL: rotate left.
  - Any other opcode is illegal.
- States:
  - IDLE:
    - accept on in_valid && in_ready.
    - Load X←A, rem←amt, op←instruction, carry←0, err←illegal.
    - Go to DONE if amt = 0 or the opcode is illegal; otherwise go to SHIFT.
  - SHIFT, each clock:
    - k = min(rem, STEP).
    - X is shifted or rotated by k.
    - carry takes the last bit moved out or wrapped.
    - rem ← rem − k.
    - When rem ≤ STEP, go to DONE.
  - DONE:
    - Hold X, carry, zero and err stable.
    - On out_valid && out_ready, go to IDLE.
- Amounts ≥ WIDTH:
  - Logical shifts give 0.
  - SRA gives all sign bits.
  - Rotates wrap naturally (amount mod WIDTH); no modulo hardware.
- Illegal opcode: X = A, err = 1, carry = 0.
- Inputs are ignored outside IDLE.
- zero is computed from the X register, so it is valid together with X.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1.
  - out_valid = 0, X = 0, carry = 0, zero = 1, err = 0.
- N = ceil(amt/STEP).
- Accept at edge k: out_valid rises after edge k+N, so after edge k when N = 0.
- Latency is N+1 cycles from the accept cycle to the first out_valid cycle.
- No accept in the DONE cycle. The minimum issue interval is N+2 cycles with out_ready held high.
- out_ready low in DONE stalls indefinitely; all outputs stay stable.
- rst_n low mid-SHIFT or mid-DONE:
  - Immediately returns all registers to reset values.
  - The result is lost; no out_valid pulse follows.
- in_valid high during SHIFT or DONE has no effect and is not queued.

## Structure
- alu_pkg, shared with the other ALU units:
  - 4-bit opcode localparams OP_SRL, OP_SLL, OP_SRA, OP_ROR, OP_ROL.
  - State enum IDLE/SHIFT/DONE.
- Sub-module shift_step, combinational:
  - Inputs: op, X, k.
  - Outputs: next X and carry-out.
  - Parametrised by WIDTH and STEP.
  - Instantiated once in alu_seq_shifter.

## Test plan
All cases use WIDTH = 6 unless stated.
- STEP = 1, SRL:
  - Stimulus: 0110, A = 111000, B = 000011.
  - Response: X = 000111, carry = 0, zero = 0; out_valid rises 3 edges after accept.
- STEP = 1, SLL:
  - Stimulus: 0111, A = 101010, B = 111011 (amount 3).
  - Response: X = 010000, carry = 1.
- STEP = 2, SRA:
  - Stimulus: 1000, A = 101010, B = 101010 (amount 2).
  - Response: X = 111010, carry = 1; out_valid 1 edge after accept.
- STEP = 1, ROR over-rotate:
  - Stimulus: 1001, A = 111000, B = 000111 (amount 7).
  - Response: X = 011100, carry = 0; 7 SHIFT cycles.
- Illegal opcode with stalled consumer:
  - Stimulus: 1111, A = 001100; out_ready held low 5 cycles.
  - Response: err = 1, X = 001100; out_valid held and outputs stable until out_ready, then in_ready returns.
- Reset mid-shift:
  - Stimulus: SLL, A = 111111, B = 5, STEP = 1; rst_n pulsed low after 2 shift cycles.
  - Response: X = 0, zero = 1, out_valid = 0, in_ready = 1 immediately; a new SRL accepts normally afterwards.
